// File: rtl/obj_spawn_sched.sv
// obj_spawn_sched: four-slot falling-object pool with LFSR spawn positions and level-dependent spawn gap
module obj_spawn_sched #(
  parameter int MAX_X    = 640,
  parameter int MAX_Y    = 480,
  parameter int OBJ_SIZE = 20,
  parameter int SPAWN_Y  = 16,
  parameter int BASE_GAP = 60,
  parameter int GAP_STEP = 10,
  parameter int MIN_GAP  = 20,
  parameter int BASE_V   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refr_tick,
  input  logic        run,
  input  logic [1:0]  level,
  input  logic        hit_valid,
  input  logic [1:0]  hit_slot,
  output logic [3:0]  obj_valid,
  output logic [39:0] obj_x,
  output logic [39:0] obj_y,
  output logic        escape
);
  logic [15:0] lfsr;
  logic [7:0]  gap, gap_n, gap_dec, gap_sub, reload;
  logic [3:0]  free_low, spawn_sel, hit_mask, esc, valid_n;
  logic [39:0] x_n, y_n;
  logic [10:0] x_raw, y_sum;
  logic [9:0]  x_spawn;
  logic        tick_run, spawn_go, escape_n;
  always_comb begin
    gap_dec   = 8'(GAP_STEP) * {6'd0, level};
    gap_sub   = 8'(BASE_GAP) - gap_dec;
    reload    = (gap_dec > 8'(BASE_GAP) || gap_sub < 8'(MIN_GAP)) ? 8'(MIN_GAP) : gap_sub;
    tick_run  = refr_tick && run;
    free_low  = ~obj_valid & (obj_valid + 4'd1);
    // counter value 1 means this tick is the last of the gap, so the spawn lands on the reload-th tick
    spawn_go  = tick_run && gap <= 8'd1 && free_low != 4'd0;
    spawn_sel = spawn_go ? free_low : 4'd0;
    x_raw     = {2'b0, lfsr[8:0]} + 11'd64;
    x_spawn   = (x_raw + 11'(OBJ_SIZE) > 11'(MAX_X)) ? 10'(MAX_X - OBJ_SIZE) : x_raw[9:0];
    hit_mask  = hit_valid ? 4'd1 << hit_slot : 4'd0;
    x_n       = obj_x;
    y_n       = obj_y;
    esc       = 4'd0;
    y_sum     = 11'd0;
    for (int i = 0; i < 4; i++) begin
      y_sum  = {1'b0, obj_y[10*i +: 10]} + 11'(BASE_V) + {9'd0, level};
      esc[i] = tick_run && obj_valid[i] && y_sum >= 11'(MAX_Y);
      x_n[10*i +: 10] = spawn_sel[i] ? x_spawn : obj_x[10*i +: 10];
      y_n[10*i +: 10] = spawn_sel[i] ? 10'(SPAWN_Y) :
                        (tick_run && obj_valid[i] && !esc[i]) ? y_sum[9:0] : obj_y[10*i +: 10];
    end
    valid_n  = run ? ((obj_valid & ~esc & ~hit_mask) | spawn_sel) : 4'd0;
    escape_n = run && |(esc & ~hit_mask);
    gap_n    = (!run || spawn_go) ? reload : (tick_run && gap != 8'd0) ? gap - 8'd1 : gap;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= 16'hACE1;
      gap       <= 8'(BASE_GAP);
      obj_valid <= 4'd0;
      obj_x     <= 40'd0;
      obj_y     <= 40'd0;
      escape    <= 1'b0;
    end else begin
      lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      gap       <= gap_n;
      obj_valid <= valid_n;
      obj_x     <= x_n;
      obj_y     <= y_n;
      escape    <= escape_n;
    end
  end
endmodule

// File: tb/tb_obj_spawn_sched.sv
// tb_obj_spawn_sched: directed scenarios plus random traffic checked against a tick-counting reference model
module tb_obj_spawn_sched;
  logic        clk = 0, rst = 1, refr_tick = 0, run = 0, hit_valid = 0;
  logic [1:0]  level = 0, hit_slot = 0;
  logic [3:0]  obj_valid;
  logic [39:0] obj_x, obj_y;
  logic        escape;
  int checks = 0, errors = 0;
  bit          m_valid [4];
  int          m_x [4], m_y [4];
  int          m_need, m_cnt;
  logic [15:0] m_lfsr;
  bit          m_esc;

  obj_spawn_sched dut (
    .clk(clk), .rst(rst), .refr_tick(refr_tick), .run(run), .level(level),
    .hit_valid(hit_valid), .hit_slot(hit_slot), .obj_valid(obj_valid),
    .obj_x(obj_x), .obj_y(obj_y), .escape(escape)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int reload_of(input int l);
    int r = 60 - 10 * l;
    return r < 20 ? 20 : r;
  endfunction

  function automatic logic [3:0] vmask();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_need = 60; m_cnt = 0; m_lfsr = 16'hACE1; m_esc = 0;
  endfunction

  // m_cnt counts ticks since the last reload; a spawn is due once it reaches m_need
  function automatic void model_step(input bit t, input bit hv, input int hs);
    logic [15:0] l = m_lfsr;
    int sp = -1;
    int ny;
    m_lfsr = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    m_esc = 0;
    if (!run) begin
      for (int i = 0; i < 4; i++) m_valid[i] = 0;
      m_cnt = 0;
      m_need = reload_of(int'(level));
      return;
    end
    if (t) begin
      m_cnt++;
      if (m_cnt >= m_need)
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) sp = i;
      for (int i = 0; i < 4; i++) if (m_valid[i]) begin
        ny = m_y[i] + 2 + int'(level);
        if (ny >= 480) begin
          m_valid[i] = 0;
          if (!(hv && hs == i)) m_esc = 1;
        end else m_y[i] = ny;
      end
    end
    if (hv) m_valid[hs] = 0;
    if (sp >= 0) begin
      m_valid[sp] = 1;
      m_x[sp] = int'(l[8:0]) + 64;
      m_y[sp] = 16;
      m_cnt = 0;
      m_need = reload_of(int'(level));
    end
  endfunction

  task automatic compare_all();
    check("valid", 64'(obj_valid), 64'(vmask()));
    check("escape", 64'(escape), 64'(m_esc));
    for (int i = 0; i < 4; i++) if (m_valid[i]) begin
      check($sformatf("x%0d", i), 64'(obj_x[10*i +: 10]), 64'(m_x[i]));
      check($sformatf("y%0d", i), 64'(obj_y[10*i +: 10]), 64'(m_y[i]));
    end
  endtask

  task automatic step(input bit t, input bit hv, input int hs);
    refr_tick = t; hit_valid = hv; hit_slot = 2'(hs);
    @(posedge clk);
    model_step(t, hv, hs);
    #1;
    refr_tick = 0; hit_valid = 0;
    compare_all();
  endtask

  initial begin
    int n, k, esc_at;
    bit found;
    #12;
    check("rst_valid", 64'(obj_valid), 0);
    check("rst_x", 64'(obj_x), 0);
    check("rst_y", 64'(obj_y), 0);
    check("rst_esc", 64'(escape), 0);
    model_reset();
    rst = 0;
    run = 1; level = 0;
    for (int i = 0; i < 59; i++) step(1, 0, 0);
    check("pre_spawn", 64'(obj_valid), 0);
    step(1, 0, 0);
    check("first_spawn", 64'(obj_valid), 4'b0001);
    check("first_y", 64'(obj_y[9:0]), 16);
    check("x_range", 64'(obj_x[9:0] >= 64 && obj_x[9:0] <= 575), 1);
    step(0, 1, 3);
    check("hit_invalid", 64'(obj_valid), 4'b0001);
    level = 2;
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    check("y_lvl2", 64'(obj_y[9:0]), 56);

    level = 0; run = 0; step(0, 0, 0); run = 1;
    for (int i = 0; i < 60; i++) step(1, 0, 0);
    check("respawn", 64'(obj_valid), 4'b0001);
    esc_at = 0;
    for (int i = 1; i <= 300; i++) begin
      step(1, 0, 0);
      if (escape && esc_at == 0) begin
        esc_at = i;
        check("esc_clears0", 64'(obj_valid[0]), 0);
      end
    end
    check("esc_tick", 64'(esc_at), 232);

    level = 1; run = 0; step(0, 0, 0); run = 1;
    n = 0;
    while (vmask() != 4'hF && n < 400) begin
      level = (m_cnt + 1 >= m_need) ? 2'd1 : 2'd0;
      step(1, 0, 0); n++;
    end
    check("full", 64'(obj_valid), 4'hF);
    level = 0;
    while (m_cnt < m_need && n < 600) begin step(1, 0, 0); n++; end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      check("full_hold", 64'(obj_valid), 4'hF);
      check("hold_esc", 64'(escape), 0);
    end
    step(0, 1, 2);
    check("hit2", 64'(obj_valid), 4'b1011);
    step(1, 0, 0);
    check("refill", 64'(obj_valid), 4'hF);
    check("refill_y", 64'(obj_y[29:20]), 16);

    found = 0; n = 0;
    while (!found && n < 400) begin
      if (m_valid[1] && m_y[1] + 2 >= 480) begin
        step(1, 1, 1);
        found = 1;
        check("coll_valid", 64'(obj_valid[1]), 0);
      end else step(1, 0, 0);
      n++;
    end
    check("coll_found", 64'(found), 1);

    n = 0;
    while ($countones(vmask()) != 3 && n < 400) begin step(1, 0, 0); n++; end
    check("three_live", 64'($countones(obj_valid)), 3);
    level = 3; run = 0;
    step(1, 0, 0);
    check("stop_valid", 64'(obj_valid), 0);
    check("stop_esc", 64'(escape), 0);
    run = 1;
    k = 0;
    while (obj_valid == 0 && k < 100) begin step(1, 0, 0); k++; end
    check("restart", 64'(k), 30);

    for (int i = 0; i < 20; i++) step(1, 0, 0);
    #2 rst = 1;
    #1;
    check("arst_valid", 64'(obj_valid), 0);
    check("arst_x", 64'(obj_x), 0);
    check("arst_y", 64'(obj_y), 0);
    check("arst_esc", 64'(escape), 0);
    model_reset();
    #1 rst = 0;

    for (int i = 0; i < 3000; i++) begin
      if (run ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 9) == 0)) run = !run;
      if ($urandom_range(0, 49) == 0) level = 2'($urandom_range(0, 3));
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, int'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
